digital_signal_acquisition: RTL

- Logic-analyser capture engine: the receive side of the digital signal generation path.
- Samples a WIDTH-bit digital bus at a programmable rate into an internal circular buffer, with pre-trigger history.
- Detects a masked level or edge trigger, then captures the post-trigger samples.
- Streams the finished capture, oldest sample first, over a valid/ready interface to the display/host path.

---
 rtl/digital_signal_acquisition.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/digital_signal_acquisition.sv
// Logic-analyser capture engine: divided-rate sampling into a circular buffer,
// masked level/edge trigger with pre-trigger history, valid/ready readout.
module digital_signal_acquisition #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 10,
   parameter int DIV_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              abort,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic [ADDR_W-1:0] pre_count,
   input  logic [WIDTH-1:0]  trig_mask,
   input  logic [WIDTH-1:0]  trig_value,
   input  logic              trig_edge,
   input  logic [WIDTH-1:0]  din,
   output logic              busy,
   output logic              triggered,
   output logic              done,
   output logic              rd_valid,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_last,
   input  logic              rd_ready
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_W:0] RD_TOTAL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] RD_LASTIDX = (ADDR_W+1)'(DEPTH-1);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_WAIT, S_POST, S_READ
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0]  sync1, sync2;
   logic [DIV_W-1:0]  cfg_div, div_cnt;
   logic [ADDR_W-1:0] cfg_pre, cnt, waddr, raddr, post_left;
   logic [WIDTH-1:0]  cfg_mask, cfg_value;
   logic              cfg_edge, prev_match;
   logic [ADDR_W:0]   rd_cnt;
   logic [WIDTH-1:0]  mem [DEPTH];

   logic start, capturing, strobe, match, trig, rd_fire, rd_load;

   assign start     = arm && !abort && (state_q == S_IDLE);
   assign capturing = state_q inside {S_PRE, S_WAIT, S_POST};
   assign strobe    = capturing && (div_cnt == cfg_div);
   assign match     = ((sync2 ^ cfg_value) & cfg_mask) == '0;
   assign trig      = (state_q == S_WAIT) && strobe && match
                      && (!cfg_edge || !prev_match);
   assign post_left = ADDR_MAX - cfg_pre;
   assign rd_fire   = rd_valid && rd_ready;
   assign rd_load   = (state_q == S_READ) && (rd_cnt != RD_TOTAL)
                      && (!rd_valid || rd_ready);

   assign busy = capturing;
   assign done = (state_q == S_READ);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = (pre_count == '0) ? S_WAIT : S_PRE;
         S_PRE:  if (strobe && cnt == ADDR_W'(1)) state_d = S_WAIT;
         S_WAIT: if (trig) state_d = (post_left == '0) ? S_READ : S_POST;
         S_POST: if (strobe && cnt == ADDR_W'(1)) state_d = S_READ;
         S_READ: if (rd_fire && rd_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // Configuration is frozen at arm so the host may retune during a capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_div   <= '0;
         cfg_pre   <= '0;
         cfg_mask  <= '0;
         cfg_value <= '0;
         cfg_edge  <= 1'b0;
      end else if (start) begin
         cfg_div   <= clk_div;
         cfg_pre   <= pre_count;
         cfg_mask  <= trig_mask;
         cfg_value <= trig_value;
         cfg_edge  <= trig_edge;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         waddr   <= '0;
         cnt     <= '0;
      end else if (start) begin
         div_cnt <= '0;
         waddr   <= '0;
         cnt     <= pre_count;
      end else if (capturing) begin
         div_cnt <= strobe ? '0 : div_cnt + 1'b1;
         if (strobe) waddr <= waddr + 1'b1;
         if (trig) cnt <= post_left;
         else if (strobe && state_q != S_WAIT) cnt <= cnt - 1'b1;
      end
   end

   // Forcing prev_match high on WAIT entry blocks an edge on an already-true condition
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_match <= 1'b0;
      else if (state_d == S_WAIT && state_q != S_WAIT) prev_match <= 1'b1;
      else if (state_q == S_WAIT && strobe) prev_match <= match;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) triggered <= 1'b0;
      else if (state_d == S_IDLE) triggered <= 1'b0;
      else if (trig) triggered <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (strobe) mem[waddr] <= sync2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raddr    <= '0;
         rd_cnt   <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_last  <= 1'b0;
      end else if (trig) begin
         raddr  <= waddr - cfg_pre;
         rd_cnt <= '0;
      end else if (state_q != S_READ || abort) begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else if (rd_load) begin
         rd_data  <= mem[raddr];
         rd_valid <= 1'b1;
         rd_last  <= (rd_cnt == RD_LASTIDX);
         raddr    <= raddr + 1'b1;
         rd_cnt   <= rd_cnt + 1'b1;
      end else if (rd_fire) begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end
   end

endmodule
